// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared constants and types for the switch conditioning front end
//
// Purpose : default sizing, board switch index map, settle FSM state type and a
//           counter-width helper used by switch_debounce and switch_debounce_bit.
// Ports   : none (package).
package switch_pkg;

    localparam int NUM_SW_DEFAULT          = 11;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int PRESCALE_DEFAULT        = 50;

    // Board switch map as seen by the user control block.
    localparam int SW_EXT_CLK   = 10;
    localparam int SW_DISP_SEL  = 9;
    localparam int SW_CLK_SEL   = 8;
    localparam int SW_VALUE_MSB = 5;
    localparam int SW_VALUE_LSB = 0;

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } settle_state_e;

    // Bits needed to hold the value max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// rtl/switch_debounce_bit.sv - two-flop synchroniser plus stability counter for one switch
//
// Purpose : brings one raw switch level into the clock domain and only accepts a
//           new level after it has differed from the current output for
//           DEBOUNCE_CYCLES consecutive count-enable cycles.
// Ports   : clk, rst_n   - clock, asynchronous active-low reset
//           sw_in        - raw asynchronous switch level
//           count_en     - counter advance qualifier (every clock or prescaler tick)
//           chg_en       - allows the change pulse (low while the block settles)
//           sw_out       - debounced level
//           changed      - one-cycle pulse when sw_out toggles (if chg_en)
module switch_debounce_bit
    import switch_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_in,
    input  logic count_en,
    input  logic chg_en,
    output logic sw_out,
    output logic changed
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          out_q, out_d;
    logic          changed_q, changed_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d   = sw_in;
        sync2_d   = sync1_q;
        out_d     = out_q;
        cnt_d     = cnt_q;
        changed_d = 1'b0;
        // A matching sample wipes any progress immediately, even between
        // prescaler ticks, so a glitch never earns partial credit.
        if (sync2_q == out_q) begin
            cnt_d = '0;
        end else if (count_en) begin
            if (cnt_q >= CNT_LAST) begin
                out_d     = sync2_q;
                cnt_d     = '0;
                changed_d = chg_en;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= RESET_BIT;
            sync2_q   <= RESET_BIT;
            out_q     <= RESET_BIT;
            cnt_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
        end
    end

    assign sw_out  = out_q;
    assign changed = changed_q;

endmodule

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - debounced switch vector with settle-valid flag and change pulses
//
// Purpose : NUM_SW independent synchronise-and-debounce channels, a settle FSM
//           that raises sw_valid after DEBOUNCE_CYCLES+2 count-enable cycles, and
//           (optionally) a count-enable prescaler.
// Ports   : clk, rst_n   - clock, asynchronous active-low reset
//           sw_in        - raw switch levels [NUM_SW]
//           sw_out       - debounced levels [NUM_SW]
//           sw_changed   - one-cycle toggle pulses [NUM_SW], zero until sw_valid
//           sw_valid     - high once the post-reset settle window has elapsed
// Macro   : SWITCH_DEBOUNCE_PRESCALE_EN - counters advance only every PRESCALE
//           clocks; when undefined every clock counts and no prescaler exists.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int                NUM_SW          = NUM_SW_DEFAULT,
    parameter int                DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic [NUM_SW-1:0] RESET_VAL       = '0,
    parameter int                PRESCALE        = PRESCALE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw_in,
    output logic [NUM_SW-1:0] sw_out,
    output logic [NUM_SW-1:0] sw_changed,
    output logic              sw_valid
);

    if (DEBOUNCE_CYCLES < 1 || PRESCALE < 1) begin : g_bad_param
        $error("switch_debounce: DEBOUNCE_CYCLES and PRESCALE must be >= 1");
    end

    logic count_en;

`ifdef SWITCH_DEBOUNCE_PRESCALE_EN
    localparam int            PW       = cnt_width(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;

    // Free-running divider; the tick is the last count of each period.
    always_comb begin
        count_en = (pre_q == PRE_LAST);
        pre_d    = count_en ? '0 : pre_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign count_en = 1'b1;
`endif

    // Settle window: long enough for a level present at reset release to pass
    // through the synchroniser and fully qualify before outputs are trusted.
    localparam int            SW_W        = cnt_width(DEBOUNCE_CYCLES + 1);
    localparam logic [SW_W-1:0] SETTLE_LAST = SW_W'(DEBOUNCE_CYCLES + 1);

    settle_state_e   state_q, state_d;
    logic [SW_W-1:0] settle_q, settle_d;
    logic            valid_q, valid_d;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        valid_d  = valid_q;
        case (state_q)
            SETTLE: begin
                if (count_en) begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = RUN;
                        valid_d = 1'b1;
                    end else begin
                        settle_d = settle_q + SW_W'(1);
                    end
                end
            end
            RUN: begin
                valid_d = 1'b1;
            end
            default: begin
                state_d = SETTLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SETTLE;
            settle_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            valid_q  <= valid_d;
        end
    end

    assign sw_valid = valid_q;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
        switch_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_BIT      (RESET_VAL[i])
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .sw_in   (sw_in[i]),
            .count_en(count_en),
            .chg_en  (valid_q),
            .sw_out  (sw_out[i]),
            .changed (sw_changed[i])
        );
    end

endmodule
